neuron_state_pipe: RTL and testbench
====================================

# neuron_state_pipe

Parametrised, pipelined neuron-state update engine. It supersedes the single-cycle LIF/Izhikevich state block for the LIF family. It sits between the neuron-state SRAM read port and its write-back path, and consumes one event per accepted cycle. Each event carries the neuron's membrane potential, refractory count and threshold. The engine returns the updated state, a spike flag and a passthrough tag under valid/ready flow control. It adds selectable leak modes, selectable reset behaviour, saturation and a spike counter.

## Interface
Parameters:
- W_MEM, 20: signed membrane-potential width.
- W_W, 8: unsigned synaptic-weight width.
- W_REC, 3: refractory-counter width.
- W_TAG, 8: passthrough tag width (neuron address).
- REFRAC, 2: refractory value loaded on spike.
- LEAK_SHIFT, 4: shift amount for proportional leak.
- LEAK_CONST, 16: step size for constant leak.
- V_MIN, -262144: lower clamp for the potential.

Ports (reset is asynchronous and active-high; the design has one clock):
- CLK, in, 1: clock.
- RST, in, 1: asynchronous active-high reset.
- in_valid, in, 1: an event is presented.
- in_ready, out, 1: the engine accepts the event this cycle.
- in_event, in, 2: 0 LEAK, 1 EXC, 2 INH, 3 CLEAR.
- in_mode, in, 2: leak mode. 0 proportional, 1 none (IF), 2 constant-toward-zero, 3 reserved (behaves as 1).
- in_reset_sub, in, 1: reset behaviour on spike. 0 resets to zero, 1 subtracts the threshold.
- in_v, in, W_MEM signed: current potential.
- in_rec, in, W_REC: current refractory count.
- in_thr, in, W_MEM signed: firing threshold.
- in_weight, in, W_W unsigned: synaptic weight.
- in_tag, in, W_TAG: tag.
- out_valid, out, 1: output result is valid.
- out_ready, in, 1: downstream accepts the result.
- out_v, out, W_MEM signed: updated potential.
- out_rec, out, W_REC: updated refractory count.
- out_spike, out, 1: spike flag.
- out_tag, out, W_TAG: tag returned with the result.
- cnt_clr, in, 1: clears the spike counter.
- spike_count, out, 16: saturating spike count.

## Operation
- LEAK with rec≠0: rec−1, v unchanged.
- LEAK with rec=0, mode 0: v − (v>>>LEAK_SHIFT), arithmetic shift (floor). Mode 1: v unchanged. Mode 2: v moves toward 0 by LEAK_CONST, stops at 0, never crosses.
- LEAK never produces a spike.
- EXC/INH with rec≠0: v and rec pass through unchanged, no spike.
- EXC with rec=0: s = v + zero-extended weight. INH with rec=0: s = v − weight.
- Arithmetic is done at W_MEM+1 bits, then saturated to [V_MIN, 2^(W_MEM−1)−1].
- Spike condition: EXC or INH, rec=0, and saturated s ≥ in_thr (signed compare).
- On spike: out_spike=1 and out_rec=REFRAC. out_v is 0 when in_reset_sub=0; otherwise it is s − thr, saturated.
- CLEAR: v=0, rec=0, no spike.
- spike_count increments by 1 on each output handshake (out_valid & out_ready) that carries a spike, and saturates at 0xFFFF.
- cnt_clr has priority over an increment in the same cycle.

## Timing
- Two-stage pipeline. Stage 1: leak/accumulate and saturate. Stage 2: threshold, reset and refractory, registered onto the outputs.
- Latency is 2 cycles from input handshake to out_valid when there is no stall. Throughput is 1 event per cycle.
- Global enable en = !out_valid | out_ready. in_ready = en. Both stages advance only when en=1.
- While a stall is in progress, all out_* signals hold stable and no event is lost or duplicated.
- Bubbles propagate as valid=0. A stage's data registers do not need to be cleared when it holds a bubble.
- Reset: out_valid=0, both stage-valid bits=0, out_v=0, out_rec=0, out_spike=0, out_tag=0, spike_count=0.
- RST asserted mid-stream discards all in-flight events. in_ready is 1 in the first cycle after reset is released.
- Dependent events on the same neuron (read-after-write hazards) are the caller's responsibility; the engine does not forward results.

## Structure
- Shared package neuron_pkg holds:
  - event codes EV_LEAK, EV_EXC, EV_INH, EV_CLR;
  - mode constants LEAK_PROP, LEAK_NONE, LEAK_CONST;
  - the saturate function.
- One combinational sub-module, neuron_leak_unit, takes (v, mode, LEAK_SHIFT, LEAK_CONST) and returns the leaked v. It is instantiated in stage 1.

## Test plan
- LEAK, mode 0, v=1600, rec=0 -> out_v=1500. With v=−1600 -> out_v=−1500. Both with out_spike=0 and latency 2.
- EXC, v=1000, w=50, thr=1024, reset_sub=0 -> out_spike=1, out_v=0, out_rec=2, spike_count=1. Repeating with reset_sub=1 -> out_v=26.
- LEAK on rec=2, v=77 -> out_rec=1, v=77. Then EXC with w=255 on rec=1 -> unchanged state, no spike.
- INH, v=−262140, w=10 -> out_v=−262144 (clamp). EXC, v=524280, w=200, thr=524287 -> out_v=0 with a spike.
- Mode 2: LEAK on v=−10 -> 0; on v=40 -> 24.
- Backpressure: stream 6 events with out_ready low for cycles 3–5 -> in_ready low while out_valid & !out_ready, outputs stable, all 6 results in order. cnt_clr pulsed together with a spiking handshake -> spike_count=0.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared codes and helpers for the LIF neuron-state pipeline.
package neuron_pkg;

    typedef enum logic [1:0] {
        EV_LEAK = 2'd0,
        EV_EXC  = 2'd1,
        EV_INH  = 2'd2,
        EV_CLR  = 2'd3
    } event_e;

    localparam logic [1:0] LEAK_PROP  = 2'd0;
    localparam logic [1:0] LEAK_NONE  = 2'd1;
    localparam logic [1:0] LEAK_CONST = 2'd2;

    // Wide enough for any W_MEM the engine is built with; callers truncate the result.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                    input logic signed [63:0] lo,
                                                    input logic signed [63:0] hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

endpackage

// File: rtl/neuron_leak_unit.sv
// Combinational leak of a membrane potential: proportional, none, or constant-toward-zero.
module neuron_leak_unit #(
    parameter int W_MEM      = 20,
    parameter int LEAK_SHIFT = 4,
    parameter int LEAK_CONST = 16
) (
    input  logic signed [W_MEM-1:0] v,
    input  logic [1:0]              mode,
    output logic signed [W_MEM-1:0] v_leak
);

    localparam logic signed [W_MEM-1:0] STEP = W_MEM'(LEAK_CONST);

    always_comb begin
        v_leak = v;
        case (mode)
            neuron_pkg::LEAK_PROP:  v_leak = v - (v >>> LEAK_SHIFT);
            // Snap to zero once within one step so the potential never crosses sign.
            neuron_pkg::LEAK_CONST: begin
                if (v > STEP)       v_leak = v - STEP;
                else if (v < -STEP) v_leak = v + STEP;
                else                v_leak = '0;
            end
            default: v_leak = v;
        endcase
    end

endmodule

// File: rtl/neuron_state_pipe.sv
// Two-stage LIF neuron-state update engine: stage 1 leaks/accumulates and saturates,
// stage 2 applies threshold, reset and refractory onto the registered outputs.
module neuron_state_pipe #(
    parameter int W_MEM      = 20,
    parameter int W_W        = 8,
    parameter int W_REC      = 3,
    parameter int W_TAG      = 8,
    parameter int REFRAC     = 2,
    parameter int LEAK_SHIFT = 4,
    parameter int LEAK_CONST = 16,
    parameter int V_MIN      = -262144
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_event,
    input  logic [1:0]              in_mode,
    input  logic                    in_reset_sub,
    input  logic signed [W_MEM-1:0] in_v,
    input  logic [W_REC-1:0]        in_rec,
    input  logic signed [W_MEM-1:0] in_thr,
    input  logic [W_W-1:0]          in_weight,
    input  logic [W_TAG-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [W_MEM-1:0] out_v,
    output logic [W_REC-1:0]        out_rec,
    output logic                    out_spike,
    output logic [W_TAG-1:0]        out_tag,
    input  logic                    cnt_clr,
    output logic [15:0]             spike_count
);

    localparam logic signed [63:0] SAT_LO = 64'(V_MIN);
    localparam logic signed [63:0] SAT_HI = (64'sd1 <<< (W_MEM - 1)) - 64'sd1;

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ---------------- stage 1: leak / accumulate ----------------
    logic signed [W_MEM-1:0] v_leak;
    logic signed [W_MEM:0]   v_ext, w_ext, sum;
    logic signed [W_MEM-1:0] s1_v_d;
    logic [W_REC-1:0]        s1_rec_d;
    logic                    s1_cand_d;

    neuron_leak_unit #(
        .W_MEM      (W_MEM),
        .LEAK_SHIFT (LEAK_SHIFT),
        .LEAK_CONST (LEAK_CONST)
    ) u_leak (
        .v      (in_v),
        .mode   (in_mode),
        .v_leak (v_leak)
    );

    assign v_ext = (W_MEM+1)'(in_v);
    assign w_ext = signed'((W_MEM+1)'(in_weight));

    always_comb begin
        sum       = (neuron_pkg::event_e'(in_event) == neuron_pkg::EV_INH) ? v_ext - w_ext
                                                                           : v_ext + w_ext;
        s1_v_d    = in_v;
        s1_rec_d  = in_rec;
        s1_cand_d = 1'b0;
        case (neuron_pkg::event_e'(in_event))
            neuron_pkg::EV_LEAK: begin
                if (in_rec != '0) s1_rec_d = in_rec - 1'b1;
                else              s1_v_d   = v_leak;
            end
            neuron_pkg::EV_EXC, neuron_pkg::EV_INH: begin
                if (in_rec == '0) begin
                    s1_v_d    = W_MEM'(neuron_pkg::saturate(64'(sum), SAT_LO, SAT_HI));
                    s1_cand_d = 1'b1;
                end
            end
            default: begin
                s1_v_d   = '0;
                s1_rec_d = '0;
            end
        endcase
    end

    logic                    s1_valid;
    logic signed [W_MEM-1:0] s1_v, s1_thr;
    logic [W_REC-1:0]        s1_rec;
    logic                    s1_cand, s1_reset_sub;
    logic [W_TAG-1:0]        s1_tag;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)     s1_valid <= 1'b0;
        else if (en) s1_valid <= in_valid;
    end

    // NOTE: stage-1 data is qualified by s1_valid, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (en && in_valid) begin
            s1_v         <= s1_v_d;
            s1_rec       <= s1_rec_d;
            s1_cand      <= s1_cand_d;
            s1_thr       <= in_thr;
            s1_reset_sub <= in_reset_sub;
            s1_tag       <= in_tag;
        end
    end

    // ---------------- stage 2: threshold / reset / refractory ----------------
    logic                    spike;
    logic signed [W_MEM:0]   diff;
    logic signed [W_MEM-1:0] v2_d;
    logic [W_REC-1:0]        rec2_d;

    always_comb begin
        spike  = s1_cand && (s1_v >= s1_thr);
        diff   = (W_MEM+1)'(s1_v) - (W_MEM+1)'(s1_thr);
        v2_d   = s1_v;
        rec2_d = s1_rec;
        if (spike) begin
            v2_d   = s1_reset_sub ? W_MEM'(neuron_pkg::saturate(64'(diff), SAT_LO, SAT_HI)) : '0;
            rec2_d = W_REC'(REFRAC);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid <= 1'b0;
            out_v     <= '0;
            out_rec   <= '0;
            out_spike <= 1'b0;
            out_tag   <= '0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_v     <= v2_d;
                out_rec   <= rec2_d;
                out_spike <= spike;
                out_tag   <= s1_tag;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            spike_count <= '0;
        else if (cnt_clr)
            spike_count <= '0;
        else if (out_valid && out_ready && out_spike && spike_count != 16'hFFFF)
            spike_count <= spike_count + 16'd1;
    end

endmodule

// File: tb/tb_neuron_state_pipe.sv
// Scoreboard bench for neuron_state_pipe: driver pushes expected results, a monitor pops and compares.
module tb_neuron_state_pipe;

    localparam int     W_MEM  = 20;
    localparam int     W_W    = 8;
    localparam int     W_REC  = 3;
    localparam int     W_TAG  = 8;
    localparam int     REFRAC = 2;
    localparam int     LSHIFT = 4;
    localparam int     LCONST = 16;
    localparam longint V_MIN  = -262144;
    localparam longint V_MAX  = 524287;

    localparam int E_LEAK = 0, E_EXC = 1, E_INH = 2, E_CLR = 3;

    logic                    CLK = 1'b0;
    logic                    RST;
    logic                    in_valid, in_ready;
    logic [1:0]              in_event, in_mode;
    logic                    in_reset_sub;
    logic signed [W_MEM-1:0] in_v, in_thr;
    logic [W_REC-1:0]        in_rec;
    logic [W_W-1:0]          in_weight;
    logic [W_TAG-1:0]        in_tag;
    logic                    out_valid, out_ready;
    logic signed [W_MEM-1:0] out_v;
    logic [W_REC-1:0]        out_rec;
    logic                    out_spike;
    logic [W_TAG-1:0]        out_tag;
    logic                    cnt_clr;
    logic [15:0]             spike_count;

    neuron_state_pipe dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_event(in_event), .in_mode(in_mode),
        .in_reset_sub(in_reset_sub), .in_v(in_v), .in_rec(in_rec), .in_thr(in_thr),
        .in_weight(in_weight), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_v(out_v), .out_rec(out_rec),
        .out_spike(out_spike), .out_tag(out_tag),
        .cnt_clr(cnt_clr), .spike_count(spike_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        longint v;
        int     rec;
        bit     spike;
        int     tag;
        int     issue;
        bit     chk_lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   exp_cnt  = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint clamp(input longint x);
        if (x < V_MIN) return V_MIN;
        if (x > V_MAX) return V_MAX;
        return x;
    endfunction

    function automatic exp_t mk(input longint v, input int rec, input bit spike);
        exp_t e;
        e.v = v; e.rec = rec; e.spike = spike; e.tag = 0; e.issue = 0; e.chk_lat = 1'b1;
        return e;
    endfunction

    // Reference behaviour written straight from the update rules.
    function automatic exp_t model(input int ev, input int mode, input bit rsub, input longint v,
                                   input int rec, input longint thr, input int w);
        exp_t   e;
        longint d, q, s;
        e = mk(v, rec, 1'b0);
        e.chk_lat = 1'b0;
        if (ev == E_CLR) begin
            e.v = 0; e.rec = 0;
        end else if (ev == E_LEAK) begin
            if (rec != 0) e.rec = rec - 1;
            else if (mode == 0) begin
                d = longint'(1) << LSHIFT;
                q = (v >= 0) ? v / d : -((-v + d - 1) / d);
                e.v = v - q;
            end else if (mode == 2) begin
                if (v > 0) e.v = (v > LCONST) ? v - LCONST : 0;
                else       e.v = (v < -LCONST) ? v + LCONST : 0;
            end
        end else if (rec == 0) begin
            s = clamp((ev == E_EXC) ? v + w : v - w);
            if (s >= thr) begin
                e.spike = 1'b1;
                e.rec   = REFRAC;
                e.v     = rsub ? clamp(s - thr) : 0;
            end else begin
                e.v = s;
            end
        end
        return e;
    endfunction

    task automatic issue(input int ev, input int mode, input bit rsub, input longint v, input int rec,
                         input longint thr, input int w, input int tag, input exp_t e_in);
        exp_t e;
        int   n;
        e = e_in;
        n = 0;
        @(negedge CLK);
        in_valid = 1'b1; in_event = 2'(ev); in_mode = 2'(mode); in_reset_sub = rsub;
        in_v = W_MEM'(v); in_rec = W_REC'(rec); in_thr = W_MEM'(thr);
        in_weight = W_W'(w); in_tag = W_TAG'(tag);
        #1;
        while (!in_ready && n < 200) begin
            @(negedge CLK); #1; n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
        end else begin
            e.tag   = tag;
            e.issue = cyc;
            sb.push_back(e);
        end
        @(posedge CLK);
        #1 in_valid = 1'b0;
    endtask

    task automatic rand_event();
        int     ev, mode, rec, w, tag;
        bit     rsub;
        longint v, thr;
        ev   = $urandom_range(0, 3);
        mode = $urandom_range(0, 3);
        rsub = 1'($urandom_range(0, 1));
        rec  = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(0, 7);
        w    = $urandom_range(0, 255);
        tag  = $urandom_range(0, 255);
        case ($urandom_range(0, 3))
            0:       v = V_MAX - $urandom_range(0, 300);
            1:       v = V_MIN + $urandom_range(0, 300);
            default: v = longint'($urandom_range(0, 786431)) + V_MIN;
        endcase
        if ($urandom_range(0, 1) == 1) thr = clamp(v + longint'($urandom_range(0, 600)) - 300);
        else                           thr = longint'($urandom_range(0, 786431)) + V_MIN;
        issue(ev, mode, rsub, v, rec, thr, w, tag, model(ev, mode, rsub, v, rec, thr, w));
    endtask

    // ---------------- monitor ----------------
    logic                    held = 1'b0;
    logic signed [W_MEM-1:0] hv_v;
    logic [W_REC-1:0]        hv_rec;
    logic                    hv_spike;
    logic [W_TAG-1:0]        hv_tag;

    always @(negedge CLK) begin
        exp_t e;
        bit   hs_spike;
        #2;
        if (RST) begin
            held = 1'b0;
        end else begin
            hs_spike = 1'b0;
            check("in_ready_vs_stall", in_ready, !out_valid || out_ready);
            if (held) begin
                check("stall_valid", out_valid, 1);
                check("stall_v", out_v, hv_v);
                check("stall_rec", out_rec, hv_rec);
                check("stall_spike", out_spike, hv_spike);
                check("stall_tag", out_tag, hv_tag);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_v", out_v, e.v);
                    check("out_rec", out_rec, e.rec);
                    check("out_spike", out_spike, e.spike);
                    check("out_tag", out_tag, e.tag);
                    if (e.chk_lat) check("latency", cyc - e.issue, 2);
                    hs_spike = e.spike;
                end
            end
            check("spike_count", spike_count, exp_cnt);
            if (cnt_clr)                        exp_cnt = 0;
            else if (hs_spike && exp_cnt < 65535) exp_cnt++;
            held     = out_valid && !out_ready;
            hv_v     = out_v;
            hv_rec   = out_rec;
            hv_spike = out_spike;
            hv_tag   = out_tag;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bit done;
        RST = 1'b1; in_valid = 1'b0; in_event = '0; in_mode = '0; in_reset_sub = 1'b0;
        in_v = '0; in_rec = '0; in_thr = '0; in_weight = '0; in_tag = '0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        #23;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_v", out_v, 0);
        check("rst_out_rec", out_rec, 0);
        check("rst_out_spike", out_spike, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_spike_count", spike_count, 0);
        @(negedge CLK);
        RST = 1'b0;
        #1 check("in_ready_after_rst", in_ready, 1);

        // Directed cases with literal expectations.
        issue(E_LEAK, 0, 0, 1600, 0, 5000, 0, 1, mk(1500, 0, 0));
        issue(E_LEAK, 0, 0, -1600, 0, 5000, 0, 2, mk(-1500, 0, 0));
        issue(E_EXC, 0, 0, 1000, 0, 1024, 50, 3, mk(0, 2, 1));
        issue(E_EXC, 0, 1, 1000, 0, 1024, 50, 4, mk(26, 2, 1));
        issue(E_LEAK, 0, 0, 77, 2, 0, 0, 5, mk(77, 1, 0));
        issue(E_EXC, 0, 0, 77, 1, 0, 255, 6, mk(77, 1, 0));
        issue(E_INH, 0, 0, -262140, 0, 1000, 10, 7, mk(-262144, 0, 0));
        issue(E_EXC, 0, 0, 524280, 0, 524287, 200, 8, mk(0, 2, 1));
        issue(E_LEAK, 2, 0, -10, 0, 0, 0, 9, mk(0, 0, 0));
        issue(E_LEAK, 2, 0, 40, 0, 0, 0, 10, mk(24, 0, 0));
        issue(E_LEAK, 1, 0, 333, 0, 0, 0, 11, mk(333, 0, 0));
        issue(E_LEAK, 3, 0, -333, 0, 0, 0, 12, mk(-333, 0, 0));
        issue(E_CLR, 0, 0, 12345, 3, 0, 0, 13, mk(0, 0, 0));
        issue(E_EXC, 0, 1, -5000, 0, -6000, 100, 14, mk(1100, 2, 1));
        repeat (4) @(negedge CLK);

        // Clear of the counter wins over a spiking handshake in the same cycle.
        issue(E_EXC, 0, 0, 2000, 0, 100, 1, 20, mk(0, 2, 1));
        n = 0;
        do begin @(negedge CLK); #1; n++; end while (!out_valid && n < 20);
        cnt_clr = 1'b1;
        @(negedge CLK);
        cnt_clr = 1'b0;
        #3 check("cnt_clr_priority", spike_count, 0);
        repeat (3) @(negedge CLK);

        // Six back-to-back events with out_ready low for three cycles.
        fork
            begin
                issue(E_EXC, 0, 0, 500, 0, 400, 200, 30, model(E_EXC, 0, 0, 500, 0, 400, 200));
                for (int i = 0; i < 5; i++) rand_event();
            end
            begin
                repeat (3) @(negedge CLK);
                out_ready = 1'b0;
                repeat (3) @(negedge CLK);
                out_ready = 1'b1;
            end
        join
        repeat (6) @(negedge CLK);
        check("bp_all_drained", sb.size(), 0);

        // Reset mid-stream discards in-flight events.
        out_ready = 1'b0;
        issue(E_LEAK, 1, 0, 1, 0, 0, 0, 40, mk(1, 0, 0));
        issue(E_LEAK, 1, 0, 2, 0, 0, 0, 41, mk(2, 0, 0));
        @(negedge CLK);
        RST = 1'b1;
        sb.delete();
        exp_cnt = 0;
        #1 check("midrst_out_valid", out_valid, 0);
        @(negedge CLK);
        RST = 1'b0;
        out_ready = 1'b1;
        #1 check("midrst_in_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); #1 check("midrst_no_output", out_valid, 0);
        end

        // Randomised traffic with random backpressure and occasional counter clears.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    rand_event();
                    if ($urandom_range(0, 7) == 0) @(negedge CLK);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge CLK);
                    out_ready = ($urandom_range(0, 3) != 0);
                    cnt_clr   = ($urandom_range(0, 40) == 0);
                end
                out_ready = 1'b1;
                cnt_clr   = 1'b0;
            end
        join

        n = 0;
        while (sb.size() != 0 && n < 1000) begin @(negedge CLK); n++; end
        repeat (3) @(negedge CLK);
        check("final_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
